apb_master: RTL and testbench

- APB requester that turns a single-command valid/ready request interface into APB IDLE/SETUP/ACCESS transfers toward a single APB completer.
- Returns read data or completion status on a one-cycle response pulse.
- Sits between an internal controller (test sequencer or CPU-side bridge) and the APB slave bus; it drives PSEL/PENABLE/PADDR/PWRITE/PWDATA and samples PREADY/PRDATA.
- Bus width is 8-bit address, 32-bit data.

---
 rtl/apb_master.sv | 140 ++++++++++++++
 tb/tb_apb_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into one APB SETUP/ACCESS transfer
// and reports completion or timeout abort on a single-cycle response pulse.
module apb_master #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDRWIDTH-1:0] cmd_addr,
  input  logic [DATAWIDTH-1:0] cmd_wdata,
  output logic                 rsp_valid,
  output logic [DATAWIDTH-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic [ADDRWIDTH-1:0] PADDR,
  output logic                 PWRITE,
  output logic [DATAWIDTH-1:0] PWDATA,
  input  logic                 PREADY,
  input  logic [DATAWIDTH-1:0] PRDATA
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [ADDRWIDTH-1:0]   paddr_q, paddr_d;
  logic                   pwrite_q, pwrite_d;
  logic [DATAWIDTH-1:0]   pwdata_q, pwdata_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [DATAWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                   accept;
  logic                   timeout_hit;

  assign accept = cmd_valid && cmd_ready;

  // Wait counter saturates at all-ones so a disabled timeout can never wrap.
  assign cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));

  // State register and all datapath flops.
  always_ff @(posedge PCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (PRESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Next-state logic; completion takes priority over timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (PREADY || timeout_hit) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath: command capture, wait counting and response formation.
  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
        end
      end
      S_SETUP: cnt_d = '0;
      S_ACCESS: begin
        if (PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
        end else begin
          cnt_d = cnt_inc;
          if (timeout_hit) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

  // Bus strobes and handshake decode straight from the state register.
  always_comb begin
    cmd_ready = (state_q == S_IDLE) && !PRESET;
    PSEL      = (state_q != S_IDLE);
    PENABLE   = (state_q == S_ACCESS);
  end

  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed testbench for apb_master: reset, zero-wait and wait-state transfers,
// timeout abort vs. late completion, back-to-back writes and mid-transfer reset.
module tb_apb_master;

  logic        PCLK;
  logic        PRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSEL;
  logic        PENABLE;
  logic [7:0]  PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;

  int errors = 0;
  int checks = 0;

  apb_master #(
    .DATAWIDTH(32),
    .ADDRWIDTH(8),
    .TIMEOUT  (16)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PREADY   (PREADY),
    .PRDATA   (PRDATA)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // One complete transfer. PREADY rises in ACCESS cycle number waits+1.
  // Latency counts edges from the accept edge to the edge that samples rsp_valid.
  task automatic xfer(input string tag, input logic wr, input logic [7:0] addr,
                      input logic [31:0] wdata, input int waits, input logic [31:0] rdata_in,
                      input int exp_lat, input int exp_en, input logic exp_err,
                      input logic [31:0] exp_rdata);
    int   edges;
    int   en;
    logic done;
    logic stable;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    PRDATA    = rdata_in;
    PREADY    = 1'b0;
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    cmd_addr  = ~addr;
    cmd_wdata = ~wdata;
    cmd_write = ~wr;
    check({tag, "_setup_psel"}, 32'(PSEL), 32'd1);
    check({tag, "_setup_penable"}, 32'(PENABLE), 32'd0);
    check({tag, "_paddr"}, 32'(PADDR), 32'(addr));
    check({tag, "_pwrite"}, 32'(PWRITE), 32'(wr));
    check({tag, "_pwdata"}, PWDATA, wdata);
    edges  = 0;
    en     = 0;
    done   = 1'b0;
    stable = 1'b1;
    while (!done && edges < 60) begin
      if (PENABLE) begin
        en++;
        if (PADDR !== addr || PWDATA !== wdata || PWRITE !== wr || PSEL !== 1'b1) stable = 1'b0;
        if (en == waits + 1) PREADY = 1'b1;
      end
      tick();
      edges++;
      if (rsp_valid) done = 1'b1;
    end
    PREADY = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(edges + 1), 32'(exp_lat));
    check({tag, "_access_cycles"}, 32'(en), 32'(exp_en));
    check({tag, "_stable"}, 32'(stable), 32'd1);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_psel_drop"}, {30'd0, PSEL, PENABLE}, 32'd0);
    check({tag, "_ready_at_rsp"}, 32'(cmd_ready), 32'd1);
    tick();
    check({tag, "_pulse_one_cycle"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rdata_hold"}, rsp_rdata, exp_rdata);
    check({tag, "_err_hold"}, 32'(rsp_err), 32'(exp_err));
  endtask

  initial begin
    int   npulse;
    int   nacc;
    int   nsetup;
    int   idle;
    int   edges;
    int   last;
    logic gap_ok;
    logic setup_ok;
    logic acc;

    // Reset held for two edges with a command pending.
    PRESET    = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h55;
    cmd_wdata = 32'h1234_5678;
    PREADY    = 1'b1;
    PRDATA    = 32'h0;
    tick();
    tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_psel_penable", {30'd0, PSEL, PENABLE}, 32'd0);
    check("rst_paddr", 32'(PADDR), 32'd0);
    check("rst_pwdata", PWDATA, 32'd0);
    check("rst_pwrite", 32'(PWRITE), 32'd0);
    check("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    PRESET    = 1'b0;
    cmd_valid = 1'b0;
    #1;
    check("rst_release_ready", 32'(cmd_ready), 32'd1);
    tick();
    check("rst_no_accept", 32'(PSEL), 32'd0);

    // Zero-wait write: PRDATA is noise and must not leak into rsp_rdata.
    xfer("wr0", 1'b1, 8'h3C, 32'hDEAD_BEEF, 0, 32'h1111_1111, 3, 1, 1'b0, 32'h0);

    // Read with three wait states.
    xfer("rd3", 1'b0, 8'h3C, 32'h0, 3, 32'hDEAD_BEEF, 6, 4, 1'b0, 32'hDEAD_BEEF);

    // Timeout: 16 ACCESS cycles with PREADY low, then abort.
    xfer("tmo", 1'b0, 8'h10, 32'h0, 100, 32'hA5A5_A5A5, 18, 16, 1'b1, 32'h0);

    // PREADY rises in the 16th ACCESS cycle: completion beats the timeout.
    xfer("tmo_win", 1'b0, 8'h10, 32'h0, 15, 32'h0BAD_CAFE, 18, 16, 1'b0, 32'h0BAD_CAFE);

    // Back-to-back writes to 0x00..0x03 with cmd_valid held high.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h00;
    cmd_wdata = 32'h100;
    PREADY    = 1'b1;
    npulse    = 0;
    nacc      = 0;
    nsetup    = 0;
    idle      = 0;
    edges     = 0;
    last      = 0;
    gap_ok    = 1'b1;
    setup_ok  = 1'b1;
    while (npulse < 4 && edges < 40) begin
      acc = cmd_valid && cmd_ready;
      tick();
      edges++;
      if (acc) begin
        nacc++;
        if (nacc == 4) cmd_valid = 1'b0;
        else begin
          cmd_addr  = 8'(nacc);
          cmd_wdata = 32'h100 + 32'(nacc);
        end
      end
      if (PSEL && !PENABLE) begin
        if (PADDR !== 8'(nsetup) || PWDATA !== 32'h100 + 32'(nsetup)) setup_ok = 1'b0;
        nsetup++;
      end
      if (!PSEL) idle++;
      if (rsp_valid) begin
        if (npulse > 0 && edges - last != 3) gap_ok = 1'b0;
        if (!cmd_ready || rsp_err) gap_ok = 1'b0;
        last = edges;
        npulse++;
      end
    end
    check("b2b_pulses", 32'(npulse), 32'd4);
    check("b2b_gaps", 32'(gap_ok), 32'd1);
    check("b2b_setup_addr", 32'(setup_ok), 32'd1);
    check("b2b_setups", 32'(nsetup), 32'd4);
    check("b2b_idle_cycles", 32'(idle), 32'd4);
    check("b2b_total_edges", 32'(edges), 32'd12);
    PREADY = 1'b0;
    tick();

    // Reset asserted during ACCESS with PREADY low.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h20;
    PRDATA    = 32'h7777_7777;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("mid_in_access", {30'd0, PSEL, PENABLE}, 32'd3);
    PRESET = 1'b1;
    tick();
    check("mid_psel_penable", {30'd0, PSEL, PENABLE}, 32'd0);
    check("mid_no_rsp", 32'(rsp_valid), 32'd0);
    check("mid_ready_low", 32'(cmd_ready), 32'd0);
    check("mid_paddr", 32'(PADDR), 32'd0);
    PRESET = 1'b0;
    #1;
    check("mid_release_ready", 32'(cmd_ready), 32'd1);
    tick();
    check("mid_still_no_rsp", {30'd0, rsp_valid, PSEL}, 32'd0);
    xfer("rd_ff", 1'b0, 8'hFF, 32'h0, 0, 32'hCAFE_F00D, 3, 1, 1'b0, 32'hCAFE_F00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
